z80fi_insn_collector: RTL and testbench

Upstream stage of the Z80FI per-instruction spec modules. Watches the core's decoded bus events: opcode-byte fetches, memory writes and the retire strobe. Assembles them into one retirement packet per instruction: z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata and two memory-write slots. The insn_spec checkers compare this packet against their expected behaviour.

---
 rtl/z80fi_insn_collector.sv | 176 +++++++++++++++++
 tb/tb_z80fi_insn_collector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/z80fi_insn_collector.sv
// ============================================================================
// Module  : z80fi_insn_collector
// Brief   : Assembles fetch/write/retire events into one Z80FI packet per insn.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module z80fi_insn_collector #(
    parameter int MAX_LEN = 4,
    parameter int MAX_WR  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           fetch_valid,
    input  logic                           fetch_first,
    input  logic [15:0]                    fetch_addr,
    input  logic [7:0]                     fetch_data,
    input  logic                           wr_valid,
    input  logic [15:0]                    wr_addr,
    input  logic [7:0]                     wr_data,
    input  logic                           insn_done,
    output logic                           z80fi_valid,
    output logic [8*MAX_LEN-1:0]           z80fi_insn,
    output logic [$clog2(MAX_LEN+1)-1:0]   z80fi_insn_len,
    output logic [15:0]                    z80fi_pc_rdata,
    output logic [$clog2(MAX_WR+1)-1:0]    z80fi_mem_wr_count,
    output logic [15:0]                    z80fi_mem_waddr,
    output logic [15:0]                    z80fi_mem_waddr2,
    output logic [7:0]                     z80fi_mem_wdata,
    output logic [7:0]                     z80fi_mem_wdata2,
    output logic                           z80fi_overflow
);

    localparam int C_LEN_W = $clog2(MAX_LEN + 1);
    localparam int C_CNT_W = $clog2(MAX_WR + 1);
    localparam logic [C_LEN_W-1:0] C_MAX_LEN = C_LEN_W'(MAX_LEN);
    localparam logic [C_CNT_W-1:0] C_MAX_WR  = C_CNT_W'(MAX_WR);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;

    logic [8*MAX_LEN-1:0]   r_buf;
    logic [C_LEN_W-1:0]     r_len;
    logic [15:0]            r_pc;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [15:0]            r_waddr [MAX_WR];
    logic [7:0]             r_wdata [MAX_WR];
    logic                   r_ovf;

    logic                   w_start;
    logic                   w_more;
    logic                   w_wr;
    logic                   w_emit;
    logic [8*MAX_LEN-1:0]   w_m_buf;
    logic [C_LEN_W-1:0]     w_m_len;
    logic [C_CNT_W-1:0]     w_m_cnt;
    logic [15:0]            w_m_waddr [MAX_WR];
    logic [7:0]             w_m_wdata [MAX_WR];
    logic                   w_m_ovf;

    assign w_start = fetch_valid & fetch_first;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_COLLECT;
        end else if (r_state == S_COLLECT && insn_done) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Merged view = working buffer plus this cycle's non-first byte and write;
    // this is what both the next working state and an emitted packet use.
    always_comb begin
        w_more    = fetch_valid & ~fetch_first & (r_state == S_COLLECT);
        w_wr      = wr_valid & (r_state == S_COLLECT);
        w_emit    = insn_done & (r_state == S_COLLECT);
        w_m_buf   = r_buf;
        w_m_len   = r_len;
        w_m_cnt   = r_cnt;
        w_m_waddr = r_waddr;
        w_m_wdata = r_wdata;
        w_m_ovf   = r_ovf;
        if (w_more) begin
            if (r_len < C_MAX_LEN) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (r_len == C_LEN_W'(k)) begin
                        w_m_buf[8*k +: 8] = fetch_data;
                    end
                end
                w_m_len = r_len + C_LEN_W'(1);
            end else begin
                w_m_ovf = 1'b1;
            end
        end
        if (w_wr) begin
            if (r_cnt < C_MAX_WR) begin
                for (int k = 0; k < MAX_WR; k++) begin
                    if (r_cnt == C_CNT_W'(k)) begin
                        w_m_waddr[k] = wr_addr;
                        w_m_wdata[k] = wr_data;
                    end
                end
                w_m_cnt = r_cnt + C_CNT_W'(1);
            end else begin
                w_m_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf              <= '0;
            r_len              <= '0;
            r_pc               <= '0;
            r_cnt              <= '0;
            r_waddr            <= '{default: '0};
            r_wdata            <= '{default: '0};
            r_ovf              <= 1'b0;
            z80fi_valid        <= 1'b0;
            z80fi_insn         <= '0;
            z80fi_insn_len     <= '0;
            z80fi_pc_rdata     <= '0;
            z80fi_mem_wr_count <= '0;
            z80fi_mem_waddr    <= '0;
            z80fi_mem_waddr2   <= '0;
            z80fi_mem_wdata    <= '0;
            z80fi_mem_wdata2   <= '0;
            z80fi_overflow     <= 1'b0;
        end else begin
            if (w_start) begin
                r_buf   <= {{(8*(MAX_LEN-1)){1'b0}}, fetch_data};
                r_len   <= C_LEN_W'(1);
                r_pc    <= fetch_addr;
                r_cnt   <= '0;
                r_waddr <= '{default: '0};
                r_wdata <= '{default: '0};
                r_ovf   <= 1'b0;
            end else if (r_state == S_COLLECT) begin
                r_buf   <= w_m_buf;
                r_len   <= w_m_len;
                r_cnt   <= w_m_cnt;
                r_waddr <= w_m_waddr;
                r_wdata <= w_m_wdata;
                r_ovf   <= w_m_ovf;
            end

            z80fi_valid <= w_emit;
            if (w_emit) begin
                z80fi_insn         <= w_m_buf;
                z80fi_insn_len     <= w_m_len;
                z80fi_pc_rdata     <= r_pc;
                z80fi_mem_wr_count <= w_m_cnt;
                z80fi_mem_waddr    <= w_m_waddr[0];
                z80fi_mem_waddr2   <= w_m_waddr[1];
                z80fi_mem_wdata    <= w_m_wdata[0];
                z80fi_mem_wdata2   <= w_m_wdata[1];
                z80fi_overflow     <= w_m_ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_z80fi_insn_collector.sv
// ============================================================================
// Module  : tb_z80fi_insn_collector
// Brief   : Directed-vector bench for z80fi_insn_collector.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_z80fi_insn_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid, fetch_first;
    logic [15:0] fetch_addr;
    logic [7:0]  fetch_data;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        insn_done;
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata;
    logic [1:0]  z80fi_mem_wr_count;
    logic [15:0] z80fi_mem_waddr, z80fi_mem_waddr2;
    logic [7:0]  z80fi_mem_wdata, z80fi_mem_wdata2;
    logic        z80fi_overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    z80fi_insn_collector #(.MAX_LEN(4), .MAX_WR(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_valid        (fetch_valid),
        .fetch_first        (fetch_first),
        .fetch_addr         (fetch_addr),
        .fetch_data         (fetch_data),
        .wr_valid           (wr_valid),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .insn_done          (insn_done),
        .z80fi_valid        (z80fi_valid),
        .z80fi_insn         (z80fi_insn),
        .z80fi_insn_len     (z80fi_insn_len),
        .z80fi_pc_rdata     (z80fi_pc_rdata),
        .z80fi_mem_wr_count (z80fi_mem_wr_count),
        .z80fi_mem_waddr    (z80fi_mem_waddr),
        .z80fi_mem_waddr2   (z80fi_mem_waddr2),
        .z80fi_mem_wdata    (z80fi_mem_wdata),
        .z80fi_mem_wdata2   (z80fi_mem_wdata2),
        .z80fi_overflow     (z80fi_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, clock, sample 1 time unit after the edge.
    task automatic step(input logic fv, input logic ff, input logic [15:0] fa, input logic [7:0] fd,
                        input logic wv, input logic [15:0] wa, input logic [7:0] wd, input logic dn);
        fetch_valid = fv; fetch_first = ff; fetch_addr = fa; fetch_data = fd;
        wr_valid = wv; wr_addr = wa; wr_data = wd; insn_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0, 0);
    endtask

    initial begin
        reset = 1'b1;
        fetch_valid = 0; fetch_first = 0; fetch_addr = 0; fetch_data = 0;
        wr_valid = 0; wr_addr = 0; wr_data = 0; insn_done = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", z80fi_valid, 0);
        chk("rst_insn",  z80fi_insn, 0);
        chk("rst_len",   z80fi_insn_len, 0);
        chk("rst_pc",    z80fi_pc_rdata, 0);
        chk("rst_cnt",   z80fi_mem_wr_count, 0);
        reset = 1'b0;
        idle();

        // LD (0x1234),BC
        step(1, 1, 16'h0100, 8'hED, 0, 16'h0, 8'h0, 0);
        chk("ld_no_early_valid", z80fi_valid, 0);
        step(1, 0, 16'h0101, 8'h43, 0, 16'h0, 8'h0, 0);
        step(1, 0, 16'h0102, 8'h34, 0, 16'h0, 8'h0, 0);
        step(1, 0, 16'h0103, 8'h12, 1, 16'h1234, 8'hCD, 0);
        chk("ld_no_valid_before_done", z80fi_valid, 0);
        step(0, 0, 16'h0, 8'h0, 1, 16'h1235, 8'hAB, 1);
        chk("ld_valid",  z80fi_valid, 1);
        chk("ld_insn",   z80fi_insn, 32'h123443ED);
        chk("ld_len",    z80fi_insn_len, 4);
        chk("ld_pc",     z80fi_pc_rdata, 16'h0100);
        chk("ld_cnt",    z80fi_mem_wr_count, 2);
        chk("ld_waddr",  z80fi_mem_waddr, 16'h1234);
        chk("ld_wdata",  z80fi_mem_wdata, 8'hCD);
        chk("ld_waddr2", z80fi_mem_waddr2, 16'h1235);
        chk("ld_wdata2", z80fi_mem_wdata2, 8'hAB);
        chk("ld_ovf",    z80fi_overflow, 0);
        idle();
        chk("ld_valid_one_cycle", z80fi_valid, 0);
        chk("ld_insn_held",       z80fi_insn, 32'h123443ED);

        // NOP
        step(1, 1, 16'h0200, 8'h00, 0, 16'h0, 8'h0, 0);
        step(0, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0, 1);
        chk("nop_valid",  z80fi_valid, 1);
        chk("nop_insn",   z80fi_insn, 0);
        chk("nop_len",    z80fi_insn_len, 1);
        chk("nop_pc",     z80fi_pc_rdata, 16'h0200);
        chk("nop_cnt",    z80fi_mem_wr_count, 0);
        chk("nop_waddr",  z80fi_mem_waddr, 0);
        chk("nop_wdata2", z80fi_mem_wdata2, 0);
        idle();
        chk("nop_valid_once", z80fi_valid, 0);

        // Retire / start overlap, then back-to-back retire
        step(1, 1, 16'h0280, 8'h06, 0, 16'h0, 8'h0, 0);
        step(1, 0, 16'h0281, 8'h55, 0, 16'h0, 8'h0, 0);
        step(1, 1, 16'h0300, 8'h3E, 1, 16'h4000, 8'h77, 1);
        chk("ovl_valid", z80fi_valid, 1);
        chk("ovl_len",   z80fi_insn_len, 2);
        chk("ovl_insn",  z80fi_insn, 32'h00005506);
        chk("ovl_pc",    z80fi_pc_rdata, 16'h0280);
        chk("ovl_cnt",   z80fi_mem_wr_count, 1);
        chk("ovl_waddr", z80fi_mem_waddr, 16'h4000);
        step(1, 0, 16'h0301, 8'h07, 0, 16'h0, 8'h0, 1);
        chk("b2b_valid", z80fi_valid, 1);
        chk("b2b_pc",    z80fi_pc_rdata, 16'h0300);
        chk("b2b_insn",  z80fi_insn, 32'h0000073E);
        chk("b2b_cnt",   z80fi_mem_wr_count, 0);
        idle();
        chk("b2b_valid_drop", z80fi_valid, 0);

        // Overflow: 5 bytes, 3 writes
        step(1, 1, 16'h0400, 8'h01, 0, 16'h0, 8'h0, 0);
        step(1, 0, 16'h0401, 8'h02, 1, 16'h1000, 8'h11, 0);
        step(1, 0, 16'h0402, 8'h03, 1, 16'h1001, 8'h22, 0);
        step(1, 0, 16'h0403, 8'h04, 0, 16'h0, 8'h0, 0);
        step(1, 0, 16'h0404, 8'h05, 1, 16'h1002, 8'h33, 0);
        step(0, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0, 1);
        chk("ovf_valid", z80fi_valid, 1);
        chk("ovf_insn",  z80fi_insn, 32'h04030201);
        chk("ovf_len",   z80fi_insn_len, 4);
        chk("ovf_cnt",   z80fi_mem_wr_count, 2);
        chk("ovf_waddr", z80fi_mem_waddr, 16'h1000);
        chk("ovf_wdata2", z80fi_mem_wdata2, 8'h22);
        chk("ovf_flag",  z80fi_overflow, 1);
        idle();

        // Discard open packet on fresh fetch_first without retire
        step(1, 1, 16'h0700, 8'h11, 0, 16'h0, 8'h0, 0);
        step(1, 0, 16'h0701, 8'h22, 0, 16'h0, 8'h0, 0);
        step(1, 1, 16'h0710, 8'h33, 0, 16'h0, 8'h0, 0);
        chk("disc_no_valid", z80fi_valid, 0);
        step(0, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0, 1);
        chk("disc_valid", z80fi_valid, 1);
        chk("disc_pc",    z80fi_pc_rdata, 16'h0710);
        chk("disc_insn",  z80fi_insn, 32'h00000033);
        chk("disc_ovf",   z80fi_overflow, 0);
        idle();

        // Asynchronous reset mid-packet
        step(1, 1, 16'h0500, 8'hAA, 0, 16'h0, 8'h0, 0);
        step(1, 0, 16'h0501, 8'hBB, 0, 16'h0, 8'h0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_insn", z80fi_insn, 0);
        chk("arst_pc",   z80fi_pc_rdata, 0);
        chk("arst_len",  z80fi_insn_len, 0);
        chk("arst_ovf",  z80fi_overflow, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0, 1);
        chk("arst_no_valid", z80fi_valid, 0);
        idle();
        chk("arst_no_valid2", z80fi_valid, 0);

        // IDLE noise after an emitted packet
        step(1, 1, 16'h0600, 8'hC9, 0, 16'h0, 8'h0, 0);
        step(0, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0, 1);
        chk("ret_valid", z80fi_valid, 1);
        step(1, 0, 16'h0650, 8'h77, 1, 16'h2000, 8'h44, 1);
        chk("noise_no_valid", z80fi_valid, 0);
        step(0, 0, 16'h0, 8'h0, 1, 16'h2001, 8'h45, 1);
        chk("noise_no_valid2", z80fi_valid, 0);
        chk("noise_insn", z80fi_insn, 32'h000000C9);
        chk("noise_pc",   z80fi_pc_rdata, 16'h0600);
        chk("noise_cnt",  z80fi_mem_wr_count, 0);
        chk("noise_len",  z80fi_insn_len, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
